imem_loader: RTL and testbench

- Writer side of the instruction-memory interface: `Inst_mem` is only ever read by the core, and this block fills it.
- Receives a program image as a byte stream with a valid/ready handshake.
- Assembles little-endian 32-bit words, issues single-cycle write strobes to the instruction memory write port, and verifies a trailing XOR checksum.
- Holds the CPU in reset (`cpu_hold`) until a load completes successfully.

---
 rtl/imem_loader.sv | 187 ++++++++++++++++++
 tb/tb_imem_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader that fills the instruction memory and holds the core in reset until done.
// Optional inter-byte timeout enabled by defining IMEM_LOADER_TIMEOUT_EN.
module imem_loader #(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    // Largest legal image length in words (2^ADDR_W); 17 bits so ADDR_W=16 still fits.
    localparam logic [16:0] MaxWords = 17'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              active;
    logic              accept;
    logic [15:0]       len_full;
    logic [15:0]       word_cnt_inc;

    assign active       = (state_q == StLen0) || (state_q == StLen1) ||
                          (state_q == StData) || (state_q == StCsum);
    assign accept       = in_valid && active;
    assign len_full     = {in_data, len_q[7:0]};
    assign word_cnt_inc = word_cnt_q + 16'd1;

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            tmo_hit;

    assign tmo_hit = active && !accept && (tmo_q == TmoW'(TIMEOUT_CYCLES));

    always_comb begin
        tmo_d = '0;
        if (active && !accept) begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLen0;
                    len_d      = '0;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    shift_d    = '0;
                    csum_d     = '0;
                end
            end
            StLen0: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = StLen1;
                end
            end
            StLen1: begin
                if (accept) begin
                    len_d = len_full;
                    if ({1'b0, len_full} > MaxWords) begin
                        state_d = StErr;
                    end else if (len_full == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d     = csum_q ^ in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Strobe is registered, so it lands the cycle after the 4th byte.
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q[ADDR_W-1:0];
                        wdata_d    = {in_data, shift_q};
                        word_cnt_d = word_cnt_inc;
                        if (word_cnt_inc == len_q) begin
                            state_d = StCsum;
                        end
                    end else begin
                        shift_d = {in_data, shift_q[23:8]};
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? StDone : StErr;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (tmo_hit) begin
            state_d = StErr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign in_ready   = active;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign done       = (state_q == StDone);
    assign error      = (state_q == StErr);
    assign cpu_hold   = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (timeout scenario only with IMEM_LOADER_TIMEOUT_EN).
module tb_imem_loader;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                acc_cnt = 0;

    imem_loader #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (in_valid && in_ready) acc_cnt++;
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        acc_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Leaves in_valid high so consecutive calls stream one byte per cycle.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        in_data = b;
        in_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_byte: byte %02h not accepted in 40 cycles, in_ready=%0b required 1",
                     b, in_ready);
        end
    endtask

    task automatic send_image(input logic [7:0] last);
        logic [7:0] s[10];
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 10; i++) send_byte(s[i]);
        send_byte(last);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cpu_hold, in_ready, imem_we, done, error} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: hold/rdy/we/done/err=%05b required 10000",
                     {cpu_hold, in_ready, imem_we, done, error});
        end
        checks++;
        if (imem_addr !== '0 || imem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr_data: addr=%0h data=%08h required 0 0", imem_addr, imem_wdata);
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%0b cpu_hold=%0b required 0 1", in_ready, cpu_hold);
        end
    endtask

    task automatic test_good_load();
        clear_log();
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL start_to_len0: in_ready=%0b cpu_hold=%0b required 1 1", in_ready, cpu_hold);
        end
        send_image(8'h7C);
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL good_write_count: got %0d required 2", wr_addr.size());
        end else begin
            checks++;
            if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h0000_0013) begin
                errors++;
                $display("FAIL good_word0: addr=%0d data=%08h required 0 00000013",
                         wr_addr[0], wr_data[0]);
            end
            checks++;
            if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h0000_006F) begin
                errors++;
                $display("FAIL good_word1: addr=%0d data=%08h required 1 0000006f",
                         wr_addr[1], wr_data[1]);
            end
        end
        checks++;
        if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL good_status: done/err/hold/rdy=%04b required 1000",
                     {done, error, cpu_hold, in_ready});
        end
        checks++;
        if (imem_we !== 1'b0 || imem_addr !== 10'd1 || imem_wdata !== 32'h0000_006F) begin
            errors++;
            $display("FAIL good_hold_last: we=%0b addr=%0d data=%08h required 0 1 0000006f",
                     imem_we, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        pulse_start();
        checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL restart_clears_done: done=%0b cpu_hold=%0b required 0 1", done, cpu_hold);
        end
        send_image(8'h7D);
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL badcsum_write_count: got %0d required 2", wr_addr.size());
        end
        checks++;
        if ({done, error, cpu_hold} !== 3'b011) begin
            errors++;
            $display("FAIL badcsum_status: done/err/hold=%03b required 011", {done, error, cpu_hold});
        end
    endtask

    task automatic test_bad_length();
        clear_log();
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL restart_clears_error: error=%0b required 0", error);
        end
        send_byte(8'h01);
        send_byte(8'h04);
        in_valid = 1'b0;
        checks++;
        if ({error, in_ready, cpu_hold} !== 3'b101) begin
            errors++;
            $display("FAIL badlen_status: err/rdy/hold=%03b required 101", {error, in_ready, cpu_hold});
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wr_addr.size() != 0) begin
            errors++;
            $display("FAIL badlen_no_write: writes=%0d required 0", wr_addr.size());
        end
    endtask

    task automatic test_zero_length();
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        in_valid = 1'b0;
        checks++;
        if ({done, error, cpu_hold} !== 3'b100 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_len: done/err/hold=%03b writes=%0d required 100 0",
                     {done, error, cpu_hold}, wr_addr.size());
        end
    endtask

    task automatic test_max_length_and_abort();
        clear_log();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL len_1024_ok: error=%0b in_ready=%0b required 0 1", error, in_ready);
        end
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        in_valid = 1'b0;
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 10'd0 || imem_wdata !== 32'h4433_2211) begin
            errors++;
            $display("FAIL strobe_latency: we=%0b addr=%0d data=%08h required 1 0 44332211",
                     imem_we, imem_addr, imem_wdata);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({cpu_hold, in_ready, imem_we, done, error} !== 5'b10000 ||
            imem_addr !== '0 || imem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midload_reset: hold/rdy/we/done/err=%05b addr=%0h data=%08h required 10000 0 0",
                     {cpu_hold, in_ready, imem_we, done, error}, imem_addr, imem_wdata);
        end
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[7];
        s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        clear_log();
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(s[i]);
        in_data = 8'h55;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (acc_cnt != 7) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d required 7", acc_cnt);
        end
        checks++;
        if (wr_data.size() != 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: writes=%0d done=%0b required 1 1", wr_data.size(), done);
        end else begin
            checks++;
            if (wr_data[0] !== 32'h4433_2211) begin
                errors++;
                $display("FAIL b2b_word: got %08h required 44332211", wr_data[0]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hA1);
        send_byte(8'hB2);
        in_valid = 1'b0;
        pulse_start();
        checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_state: in_ready=%0b done=%0b required 1 0", in_ready, done);
        end
        send_byte(8'hC3);
        send_byte(8'hD4);
        send_byte(8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || wr_data.size() != 1) begin
            errors++;
            $display("FAIL start_ignored_load: done=%0b writes=%0d required 1 1", done, wr_data.size());
        end else begin
            checks++;
            if (wr_data[0] !== 32'hD4C3_B2A1) begin
                errors++;
                $display("FAIL start_ignored_word: got %08h required d4c3b2a1", wr_data[0]);
            end
        end
    endtask

`ifdef IMEM_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        int cycles;
        clear_log();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        in_valid = 1'b0;
        cycles = 0;
        while (error !== 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        checks++;
        if (cycles < 16 || cycles > 18) begin
            errors++;
            $display("FAIL timeout_latency: error after %0d cycles required 16..18", cycles);
        end
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_restart: error=%0b required 0", error);
        end
        send_image(8'h7C);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_recover: done=%0b error=%0b required 1 0", done, error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_bad_length();
        test_zero_length();
        test_max_length_and_abort();
        test_back_to_back();
        test_start_ignored();
`ifdef IMEM_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
